fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32 pipeline. Sits directly upstream of the Hazard unit and the decode/exec pipeline register.
- Owns the PC and issues single-beat reads to instruction memory. Holds the fetched instruction under FETCH_stall and redirects on branch/jump flush.
- Produces FETCH_valid, FETCH_rs1 and FETCH_rs2, which the Hazard unit consumes for load-use stall detection.

---
 rtl/fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 fetch; owns the PC, keeps one imem read in flight and holds its output under FETCH_stall.
// Latency is one cycle from imem_rvalid to FETCH_valid, and a one-entry skid catches a blocked response. `define FETCH_PERF_EN adds perf counters.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            FETCH_stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            FETCH_valid,
    output logic [XLEN-1:0] FETCH_pc,
    output logic [XLEN-1:0] FETCH_instr,
    output logic [4:0]      FETCH_rs1,
    output logic [4:0]      FETCH_rs2
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic            r_out_vld;
    logic [XLEN-1:0] r_out_pc, r_out_instr;
    logic            r_skid_vld;
    logic [XLEN-1:0] r_skid_pc, r_skid_instr;

    logic            w_free;
    logic            w_accept;
    logic            w_skid_vld_nxt;
    logic [XLEN-1:0] w_redirect;
    logic [XLEN-1:0] w_pc_inc;

    assign w_free     = !r_out_vld || !FETCH_stall;
    assign w_redirect = redirect_pc & ~XLEN'(3);
    assign w_pc_inc   = r_pc + XLEN'(4);
    assign w_accept   = (r_state == S_WAIT) && imem_rvalid && !flush;

    // A full skid drains into a free slot, so it refills only from a same-cycle response.
    assign w_skid_vld_nxt = !flush && (r_skid_vld ? (!w_free || w_accept)
                                                  : (w_accept && !w_free));

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        imem_req    = 1'b0;
        imem_addr   = '0;
        unique case (r_state)
            S_REQ: begin
                if (flush) begin
                    w_pc_nxt = w_redirect;
                end else if (!r_skid_vld) begin
                    imem_req    = 1'b1;
                    imem_addr   = r_pc;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_pc_nxt    = w_redirect;
                    w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    w_pc_nxt = w_pc_inc;
                    if (!w_skid_vld_nxt) begin
                        imem_req  = 1'b1;
                        imem_addr = w_pc_inc;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_DROP: begin
                if (flush) begin
                    w_pc_nxt = w_redirect;
                end
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
        if (!rst_n) begin
            imem_req  = 1'b0;
            imem_addr = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld    <= 1'b0;
            r_out_pc     <= '0;
            r_out_instr  <= '0;
            r_skid_vld   <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
        end else if (flush) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else begin
            if (w_free) begin
                if (r_skid_vld) begin
                    r_out_vld   <= 1'b1;
                    r_out_pc    <= r_skid_pc;
                    r_out_instr <= r_skid_instr;
                end else if (w_accept) begin
                    r_out_vld   <= 1'b1;
                    r_out_pc    <= r_pc;
                    r_out_instr <= imem_rdata;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end
            if (w_accept && (r_skid_vld || !w_free)) begin
                r_skid_pc    <= r_pc;
                r_skid_instr <= imem_rdata;
            end
            r_skid_vld <= w_skid_vld_nxt;
        end
    end

    assign FETCH_valid = r_out_vld;
    assign FETCH_pc    = r_out_pc;
    assign FETCH_instr = r_out_instr;
    assign FETCH_rs1   = r_out_vld ? r_out_instr[19:15] : 5'd0;
    assign FETCH_rs2   = r_out_vld ? r_out_instr[24:20] : 5'd0;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched, r_perf_dropped;
    logic        w_drop;

    assign w_drop = imem_rvalid && (((r_state == S_WAIT) && flush) || (r_state == S_DROP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
        end else begin
            if (w_accept) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_drop)   r_perf_dropped <= r_perf_dropped + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: address-keyed memory with variable latency, a transaction-level
// stream model (in-order PCs, hold under stall, flush redirect) and directed literal checks.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        FETCH_stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        FETCH_valid;
    logic [31:0] FETCH_pc;
    logic [31:0] FETCH_instr;
    logic [4:0]  FETCH_rs1;
    logic [4:0]  FETCH_rs2;

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 1;

    fetch_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .FETCH_stall(FETCH_stall), .flush(flush),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .FETCH_valid(FETCH_valid),
        .FETCH_pc(FETCH_pc), .FETCH_instr(FETCH_instr), .FETCH_rs1(FETCH_rs1),
        .FETCH_rs2(FETCH_rs2)
    );

    always #5 clk = ~clk;

    // Bijective address hash, so any stale or misplaced word is visible.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0108) return 32'h00B5_0533;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory: a request seen in a cycle is accepted at its closing edge and answered mem_lat cycles later.
    initial begin : mem_model
        logic        busy;
        int          cnt;
        logic [31:0] addr;
        logic        seen;
        logic [31:0] seen_a;
        busy = 1'b0; cnt = 0; addr = '0; seen = 1'b0; seen_a = '0;
        forever begin
            @(negedge clk);
            seen   = rst_n && imem_req;
            seen_a = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
                seen = 1'b0;
            end
            if (seen) begin
                busy = 1'b1;
                addr = seen_a;
                cnt  = (mem_lat == 0) ? int'($urandom_range(2, 0)) : mem_lat - 1;
            end
            if (busy) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_data(addr);
                    busy        = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Stream model: consumed instructions follow pc, pc+4, ... from the last reset/redirect.
    initial begin : monitor
        logic [31:0] exp_pc, exp_req, p_pc, p_instr;
        logic        p_hold, p_flush;
        int          outst, idle;
        exp_pc = RST_PC; exp_req = RST_PC; p_pc = '0; p_instr = '0;
        p_hold = 1'b0; p_flush = 1'b0; outst = 0; idle = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_valid", 32'(FETCH_valid), 32'd0);
                chk("rst_pc", FETCH_pc, 32'd0);
                chk("rst_instr", FETCH_instr, 32'd0);
                chk("rst_req", 32'(imem_req), 32'd0);
                exp_pc = RST_PC; exp_req = RST_PC; outst = 0;
                p_hold = 1'b0; p_flush = 1'b0; idle = 0;
            end else begin
                chk("rs1_field", 32'(FETCH_rs1), 32'(FETCH_valid ? FETCH_instr[19:15] : 5'd0));
                chk("rs2_field", 32'(FETCH_rs2), 32'(FETCH_valid ? FETCH_instr[24:20] : 5'd0));
                if (p_hold) begin
                    chk("hold_valid", 32'(FETCH_valid), 32'd1);
                    chk("hold_pc", FETCH_pc, p_pc);
                    chk("hold_instr", FETCH_instr, p_instr);
                end
                if (p_flush) chk("flush_kills_valid", 32'(FETCH_valid), 32'd0);
                if (FETCH_valid) chk("instr_of_pc", FETCH_instr, mem_data(FETCH_pc));
                if (FETCH_valid && !FETCH_stall && !flush) begin
                    chk("in_order_pc", FETCH_pc, exp_pc);
                    exp_pc += 32'd4;
                end
                if (flush) chk("no_req_in_flush", 32'(imem_req), 32'd0);
                if (imem_req) begin
                    chk("req_addr", imem_addr, exp_req);
                    chk("one_outstanding", 32'(outst - int'(imem_rvalid)), 32'd0);
                    exp_req += 32'd4;
                end
                outst = outst + int'(imem_req) - int'(imem_rvalid);
                if (flush) begin
                    exp_pc  = redirect_pc & 32'hFFFF_FFFC;
                    exp_req = redirect_pc & 32'hFFFF_FFFC;
                end
                p_hold  = FETCH_valid && FETCH_stall && !flush;
                p_pc    = FETCH_pc;
                p_instr = FETCH_instr;
                p_flush = flush;
                if (FETCH_valid || flush) idle = 0;
                else idle++;
                if (idle > 40) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL watchdog: no valid output for %0d cycles, required progress", idle);
                    idle = 0;
                end
            end
        end
    end

    initial begin : timeout
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        repeat (3) @(negedge clk);
        chk("reset_addr", imem_addr, 32'd0);
        chk("reset_rs1", 32'(FETCH_rs1), 32'd0);

        // Boot with 1-cycle memory, no stall.
        step(); rst_n = 1'b1;
        @(negedge clk); chk("c0_req", 32'(imem_req), 32'd1); chk("c0_addr", imem_addr, 32'h100);
        step();
        @(negedge clk); chk("c1_addr", imem_addr, 32'h104); chk("c1_valid", 32'(FETCH_valid), 32'd0);
        step();
        @(negedge clk); chk("c2_addr", imem_addr, 32'h108); chk("c2_valid", 32'(FETCH_valid), 32'd1);
        chk("c2_pc", FETCH_pc, 32'h100);
        step();
        @(negedge clk); chk("c3_pc", FETCH_pc, 32'h104);

        // Stall three cycles on add x10,x10,x11; the next word parks in the skid.
        step(); FETCH_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(FETCH_valid), 32'd1);
            chk("stall_pc", FETCH_pc, 32'h108);
            chk("stall_instr", FETCH_instr, 32'h00B5_0533);
            chk("stall_rs1", 32'(FETCH_rs1), 32'd10);
            chk("stall_rs2", 32'(FETCH_rs2), 32'd11);
            chk("stall_no_req", 32'(imem_req), 32'd0);
            step();
        end
        FETCH_stall = 1'b0;
        @(negedge clk); chk("drain_no_req", 32'(imem_req), 32'd0); chk("drain_pc", FETCH_pc, 32'h108);
        step();
        @(negedge clk); chk("skid_out_pc", FETCH_pc, 32'h10C); chk("skid_out_valid", 32'(FETCH_valid), 32'd1);
        chk("after_drain_addr", imem_addr, 32'h110);
        mem_lat = 3;

        // Flush the cycle after a 3-cycle-latency request.
        step(); flush = 1'b1; redirect_pc = 32'h200;
        step(); flush = 1'b0;
        @(negedge clk); chk("flush_valid", 32'(FETCH_valid), 32'd0); chk("drop_no_req", 32'(imem_req), 32'd0);
        n = 0;
        while (!imem_req && n < 20) begin step(); @(negedge clk); n++; end
        chk("redirect_req", 32'(imem_req), 32'd1); chk("redirect_addr", imem_addr, 32'h200);
        step(); FETCH_stall = 1'b1;
        @(negedge clk);
        n = 0;
        while (!imem_req && n < 20) begin step(); @(negedge clk); n++; end
        chk("next_addr", imem_addr, 32'h204);

        // Flush coincident with the response while stalled.
        repeat (3) step();
        flush = 1'b1; redirect_pc = 32'h301;
        @(negedge clk); chk("held_pc", FETCH_pc, 32'h200); chk("held_valid", 32'(FETCH_valid), 32'd1);
        step(); flush = 1'b0;
        @(negedge clk); chk("coinc_valid", 32'(FETCH_valid), 32'd0); chk("coinc_req", 32'(imem_req), 32'd1);
        chk("coinc_addr", imem_addr, 32'h300);
        mem_lat = 1;
        step(); FETCH_stall = 1'b0;
        @(negedge clk);
        n = 0;
        while (!FETCH_valid && n < 20) begin step(); @(negedge clk); n++; end
        chk("coinc_out_pc", FETCH_pc, 32'h300);

        // PC wrap at the top of the address space.
        step(); flush = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step(); flush = 1'b0;
        @(negedge clk);
        n = 0;
        while (!imem_req && n < 20) begin step(); @(negedge clk); n++; end
        chk("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk); chk("wrap_req", 32'(imem_req), 32'd1); chk("wrap_addr", imem_addr, 32'h0);
        step();
        @(negedge clk); chk("wrap_out_pc", FETCH_pc, 32'hFFFF_FFFC);
        step();
        @(negedge clk); chk("wrap_next_pc", FETCH_pc, 32'h0); chk("wrap_thru_valid", 32'(FETCH_valid), 32'd1);

        // Asynchronous reset with the skid full.
        step(); FETCH_stall = 1'b1;
        repeat (4) step();
        #2; rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(FETCH_valid), 32'd0); chk("arst_pc", FETCH_pc, 32'd0);
        chk("arst_instr", FETCH_instr, 32'd0); chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_addr", imem_addr, 32'd0); chk("arst_rs1", 32'(FETCH_rs1), 32'd0);
        chk("arst_rs2", 32'(FETCH_rs2), 32'd0);
        repeat (2) step();
        FETCH_stall = 1'b0; rst_n = 1'b1;
        @(negedge clk); chk("restart_req", 32'(imem_req), 32'd1); chk("restart_addr", imem_addr, RST_PC);
        n = 0;
        while (!FETCH_valid && n < 20) begin step(); @(negedge clk); n++; end
        chk("restart_pc", FETCH_pc, RST_PC);

        // Random stall/flush/latency traffic.
        mem_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            FETCH_stall = ($urandom_range(99) < 30);
            flush       = ($urandom_range(99) < 5);
            redirect_pc = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                   : $urandom();
        end
        step(); flush = 1'b0; FETCH_stall = 1'b0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
